des_key_sched_ctrl: RTL and testbench

Sequencer for the DES key schedule. It accepts one 64-bit key through a valid/ready handshake, applies PC-1, and holds the 28-bit C/D halves in registers. It then rotates the halves each round and streams the sixteen 48-bit PC-2 round keys, one per handshake, to the Feistel round datapath. It is the only owner of the C/D state: the cipher core never holds key state itself.

---
 rtl/des_key_sched_ctrl.sv | 162 ++++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: DES key-schedule sequencer.
// Takes one 64-bit key, holds the PC-1 C/D halves, and then streams the
// sixteen 48-bit PC-2 round keys, one per rk handshake.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN adds mode_i.
// With mode_i=1 the keys come out in decrypt order K16..K1.
module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic        mode_i,
`endif
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [47:0] round_key_o,
  output logic [3:0]  rk_idx_o,
  output logic        done_o
);

  typedef enum logic {IDLE, ROUND} state_t;

  // PC-1 / PC-2 selection tables, DES 1-based bit numbers (bit 1 = MSB).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Bit i is set where the round-i shift is 2 rather than 1.
  localparam logic [15:0] TWO_MASK = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_TAB[j]];
    return r;
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state, stateNext;
  logic [27:0] c, d, cNext, dNext;
  logic [47:0] rk, rkNext;
  logic [3:0]  idx, idxNext;
  logic        done, doneNext;
  logic [55:0] cd0;
  logic        decMode;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        decModeNext;
`else
  assign decMode = 1'b0;
`endif

  // State and datapath registers; reset abandons any stream in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      rk    <= '0;
      idx   <= '0;
      done  <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
      decMode <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      c     <= cNext;
      d     <= dNext;
      rk    <= rkNext;
      idx   <= idxNext;
      done  <= doneNext;
`ifdef DES_KEYSCHED_DECRYPT_EN
      decMode <= decModeNext;
`endif
    end
  end

  // Next-state, C/D rotation and round-key selection.
  always_comb begin
    stateNext = state;
    cNext     = c;
    dNext     = d;
    rkNext    = rk;
    idxNext   = idx;
    doneNext  = 1'b0;
    cd0       = pc1(key_i);
`ifdef DES_KEYSCHED_DECRYPT_EN
    decModeNext = decMode;
`endif
    case (state)
      IDLE: begin
        if (key_valid_i) begin
`ifdef DES_KEYSCHED_DECRYPT_EN
          decModeNext = mode_i;
          if (mode_i) begin
            // C0/D0 equal C16/D16, so K16 leads the decrypt stream.
            cNext = cd0[55:28];
            dNext = cd0[27:0];
          end else begin
            cNext = rol28(cd0[55:28], TWO_MASK[0]);
            dNext = rol28(cd0[27:0], TWO_MASK[0]);
          end
`else
          cNext = rol28(cd0[55:28], TWO_MASK[0]);
          dNext = rol28(cd0[27:0], TWO_MASK[0]);
`endif
          idxNext   = '0;
          rkNext    = pc2({cNext, dNext});
          stateNext = ROUND;
        end
      end
      ROUND: begin
        if (rk_ready_i) begin
          if (idx == 4'd15) begin
            stateNext = IDLE;
            cNext     = '0;
            dNext     = '0;
            rkNext    = '0;
            idxNext   = '0;
            doneNext  = 1'b1;
          end else begin
            if (decMode) begin
              cNext = ror28(c, TWO_MASK[~idx]);
              dNext = ror28(d, TWO_MASK[~idx]);
            end else begin
              cNext = rol28(c, TWO_MASK[idx + 4'd1]);
              dNext = rol28(d, TWO_MASK[idx + 4'd1]);
            end
            idxNext = idx + 4'd1;
            rkNext  = pc2({cNext, dNext});
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign key_ready_o = (state == IDLE);
  assign rk_valid_o  = (state == ROUND);
  assign round_key_o = rk;
  assign rk_idx_o    = idx;
  assign done_o      = done;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl, using the classic 133457799BBCDFF1
// key schedule and a single-bit key that walks through the C register.
module tb_des_key_sched_ctrl;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] WKEY = 64'h8000000000000000;

  localparam logic [47:0] KEXP [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  // DES bit 1 lands in C position 8. PC-2 maps that single bit as it rotates.
  // Positions 22 and 9 are dropped by PC-2, which gives a zero key. The bit is
  // back at position 8 for K16.
  localparam logic [47:0] WEXP [16] = '{
    48'h000010000000, 48'h004000000000, 48'h000100000000, 48'h000001000000,
    48'h010000000000, 48'h000080000000, 48'h100000000000, 48'h000000000000,
    48'h002000000000, 48'h000400000000, 48'h400000000000, 48'h008000000000,
    48'h000002000000, 48'h200000000000, 48'h000000000000, 48'h000040000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        keyValid, keyReady, rkValid, rkReady, done;
  logic [63:0] key;
  logic [47:0] rk;
  logic [3:0]  idx;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        mode;
`endif

  int nErr = 0;
  int nChecks = 0;

  always #5 clk = ~clk;

  des_key_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid_i (keyValid),
    .key_ready_o (keyReady),
    .key_i       (key),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .mode_i      (mode),
`endif
    .rk_valid_o  (rkValid),
    .rk_ready_i  (rkReady),
    .round_key_o (rk),
    .rk_idx_o    (idx),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int cyc;
    logic r;
    rst_n = 1'b0; keyValid = 1'b0; key = '0; rkReady = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
    mode = 1'b0;
`endif
    #3;
    chk("rst_keyReady", keyReady, 1);
    chk("rst_rkValid", rkValid, 0);
    chk("rst_rk", rk, 0);
    chk("rst_idx", idx, 0);
    chk("rst_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_keyReady", keyReady, 1);
    chk("post_rst_rkValid", rkValid, 0);

    // Encrypt stream at full rate.
    key = KEY; keyValid = 1'b1; rkReady = 1'b1;
    tick();
    keyValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("enc_vld", rkValid, 1);
      chk("enc_rk", rk, KEXP[i]);
      chk("enc_idx", idx, i);
      chk("enc_done", done, 0);
      tick();
    end
    chk("enc_done_pulse", done, 1);
    chk("enc_end_vld", rkValid, 0);
    chk("enc_end_keyReady", keyReady, 1);
    chk("enc_end_rk", rk, 0);
    tick();
    chk("enc_done_clear", done, 0);

    // Backpressure: random stalls, and the outputs must hold through each one.
    key = KEY; keyValid = 1'b1; rkReady = 1'b0;
    tick();
    keyValid = 1'b0;
    got = 0; cyc = 0;
    while (got < 16 && cyc < 200) begin
      chk("bp_vld", rkValid, 1);
      chk("bp_rk", rk, KEXP[got]);
      chk("bp_idx", idx, got);
      r = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rkReady = r;
      tick();
      if (r) got++;
      cyc++;
    end
    chk("bp_count", got, 16);
    chk("bp_done", done, 1);

    // Busy rejection: a second key is held during the stream and is taken in the done cycle.
    key = KEY; keyValid = 1'b1; rkReady = 1'b1;
    tick();
    key = WKEY;
    for (int i = 0; i < 16; i++) begin
      chk("busy_keyReady", keyReady, 0);
      chk("busy_rk", rk, KEXP[i]);
      chk("busy_idx", idx, i);
      tick();
    end
    chk("busy_done", done, 1);
    chk("busy_done_keyReady", keyReady, 1);
    tick();
    keyValid = 1'b0;
    // Rotation wrap: the set C bit walks a full 28 positions.
    for (int i = 0; i < 16; i++) begin
      chk("wrap_rk", rk, WEXP[i]);
      chk("wrap_idx", idx, i);
      tick();
    end
    chk("wrap_done", done, 1);
    tick();

    // Reset in the middle of a stream.
    key = KEY; keyValid = 1'b1;
    tick();
    keyValid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_idx7", idx, 7);
    chk("mid_rk7", rk, KEXP[7]);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", rkValid, 0);
    chk("mid_rst_rk", rk, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_keyReady", keyReady, 1);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_nodone", done, 0);
    tick();
    chk("mid_rst_nodone2", done, 0);
    key = KEY; keyValid = 1'b1;
    tick();
    keyValid = 1'b0;
    chk("restart_rk", rk, KEXP[0]);
    chk("restart_idx", idx, 0);
    tick();
    chk("restart_rk2", rk, KEXP[1]);
    for (int i = 0; i < 15; i++) tick();
    chk("restart_done", done, 1);
    tick();

`ifdef DES_KEYSCHED_DECRYPT_EN
    // Decrypt order: K16 first, K1 last.
    mode = 1'b1; key = KEY; keyValid = 1'b1;
    tick();
    keyValid = 1'b0; mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("dec_rk", rk, KEXP[15-i]);
      chk("dec_idx", idx, i);
      tick();
    end
    chk("dec_done", done, 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
